post_lcd_writer: RTL and testbench
==================================

// Module: post_lcd_writer
// PURPOSE
//  Parametrised HD44780-style LCD write engine for the POST display adapter.
//  Buffers bytes arriving from the POST port decoder in a FIFO, then emits
//  them on a 4- or 8-bit LCD bus with programmable setup/strobe/hold timing.
//  Inserts a post-write delay; the delay is longer for clear/home commands.
//  Replaces the fixed single-byte, 4-bit-only LCD path in postcode.
// PARAMETERS
//  BUS_WIDTH   4     LCD data bus width; 4 (two nibbles, high first) or 8
//  FIFO_DEPTH  16    byte FIFO entries; power of two, >=2
//  T_SETUP     1     refclk cycles RS/data are stable before lcd_e rises
//  T_EHIGH     1     refclk cycles lcd_e is high (500ns at 2MHz)
//  T_HOLD      1     refclk cycles RS/data are held after lcd_e falls
//  T_CMD       80    post-byte delay, cycles (40us at 2MHz)
//  T_SLOW      3280  post-byte delay for RS=0 bytes 0x01..0x03 (1.64ms)
// PORTS
//  refclk      in   1          2MHz reference clock; all logic on rising edge
//  reset       in   1          synchronous, active-high reset
//  wr_data     in   8          byte to display/command
//  wr_rs       in   1          LCD RS for this byte (0=command, 1=data)
//  wr_valid    in   1          write request
//  wr_ready    out  1          FIFO can accept; write occurs on valid&&ready
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued
//  overflow    out  1          sticky: wr_valid seen while wr_ready low
//  busy        out  1          engine not IDLE or FIFO non-empty
//  lcd_data    out  BUS_WIDTH  LCD data bus
//  lcd_rs      out  1          LCD register select
//  lcd_e       out  1          LCD enable strobe
// BEHAVIOUR
//  Reset (reset high at a rising edge): FIFO emptied, FSM->IDLE, lcd_e=0,
//   lcd_rs=0, lcd_data=0, overflow=0, fifo_level=0, busy=0; wr_ready=0
//   while reset is high, 1 on the first cycle after. Reset mid-strobe
//   drops lcd_e on that edge; the partial byte is discarded, never resumed.
//  FIFO: 9-bit entries {rs,data}; wr_ready = !full from the registered
//   level. A pop in the same cycle does NOT raise wr_ready when full.
//   Simultaneous push+pop with a non-full, non-empty FIFO: level unchanged.
//   Pointers wrap modulo FIFO_DEPTH. A write while !wr_ready is dropped and
//   sets overflow.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> (next nibble: SETUP) | WAIT -> IDLE
//   IDLE: FIFO non-empty -> pop; lcd_rs/lcd_data load on the same edge
//    (high nibble when BUS_WIDTH=4); enter SETUP. lcd_e stays low.
//   SETUP T_SETUP cycles; STROBE T_EHIGH cycles with lcd_e=1; HOLD T_HOLD
//    cycles with lcd_e=0 and data/rs unchanged.
//   4-bit: after the first HOLD, load the low nibble -> SETUP; the second
//    HOLD -> WAIT. 8-bit: a single pass, HOLD -> WAIT.
//   WAIT: T_SLOW cycles if rs=0 and data[7:2]==0 and data[1:0]!=0, else
//    T_CMD; then IDLE. Back-to-back bytes are never strobed inside WAIT.
//  lcd_data/lcd_rs keep their last value in WAIT/IDLE; lcd_e is glitch-free
//   (registered).
//  Default 4-bit byte: 6 cycles bus activity + 80 cycles WAIT = 86 cycles.
//   First lcd_e rises 2 cycles after the accepting write edge.
//  Timing counters: 12 bits minimum; each T_* must be >=1.
// TESTING
//  1 reset; write 0x48 rs=1 (4-bit) -> two 1-cycle E pulses, data 0x4 then
//    0x8, rs=1; busy falls 80 cycles after the second HOLD.
//  2 write 0x01 rs=0, then 0x41 rs=1 -> second byte's first E rises >=3280
//    cycles after the 0x01 low-nibble HOLD; 0x41 uses an 80-cycle WAIT.
//  3 hold wr_valid for 20 bytes, back to back -> 17 accepted (1 popped + 16
//    queued), wr_ready low, overflow=1, fifo_level=16; output order intact.
//  4 BUS_WIDTH=8 instance, write 0xA5 rs=1 -> exactly one E pulse,
//    lcd_data=0xA5 during SETUP/STROBE/HOLD.
//  5 assert reset during STROBE -> lcd_e=0 on that edge, fifo_level=0;
//    no further E strobes until new writes.
//  6 stream 10 data bytes 0x30..0x39 (4-bit) -> exactly 20 E strobes;
//    captured nibbles reassemble to 0x30..0x39 in order.

Source files
------------

// File: rtl/post_lcd_writer.sv
// HD44780-style LCD write engine: byte FIFO feeding a 4- or 8-bit bus with
// programmable setup/strobe/hold timing and a per-byte settle delay.
module post_lcd_writer #(
    parameter int unsigned BUS_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned T_SETUP    = 1,
    parameter int unsigned T_EHIGH    = 1,
    parameter int unsigned T_HOLD     = 1,
    parameter int unsigned T_CMD      = 80,
    parameter int unsigned T_SLOW     = 3280
) (
    input  logic                          refclk_i,
    input  logic                          reset_i,
    input  logic [7:0]                    wr_data_i,
    input  logic                          wr_rs_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          busy_o,
    output logic [BUS_WIDTH-1:0]          lcd_data_o,
    output logic                          lcd_rs_o,
    output logic                          lcd_e_o
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned TMax = max2(max2(T_SLOW, T_CMD), max2(max2(T_SETUP, T_EHIGH), T_HOLD));
    localparam int unsigned CntW = max2(12, $clog2(TMax + 1));

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StWait} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [7:0]            byte_q, byte_d;
    logic                  second_q, second_d;
    logic [BUS_WIDTH-1:0]  lcd_data_q, lcd_data_d;
    logic                  lcd_rs_q, lcd_rs_d;
    logic                  lcd_e_q, lcd_e_d;
    logic                  overflow_q, overflow_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [8:0]            mem_q [FIFO_DEPTH];
    logic [8:0]            head;
    logic                  push, pop, slow;

    // First beat on the bus: the whole byte, or its high nibble on a 4-bit bus.
    function automatic logic [BUS_WIDTH-1:0] first_beat(input logic [7:0] b);
        if (BUS_WIDTH == 8) return BUS_WIDTH'(b);
        else                return BUS_WIDTH'(b[7:4]);
    endfunction

    always_comb begin
        wr_ready_o = !reset_i && (level_q != LvlW'(FIFO_DEPTH));
        push       = wr_valid_i && wr_ready_o;
        overflow_d = overflow_q || (wr_valid_i && !wr_ready_o);
        head       = mem_q[rd_ptr_q];
        level_d    = level_q + LvlW'(push) - LvlW'(pop);
        wr_ptr_d   = wr_ptr_q + PtrW'(push);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        // Clear display / return home need the long settle time.
        slow       = !lcd_rs_q && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        second_d   = second_q;
        lcd_data_d = lcd_data_q;
        lcd_rs_d   = lcd_rs_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    pop        = 1'b1;
                    byte_d     = head[7:0];
                    lcd_rs_d   = head[8];
                    lcd_data_d = first_beat(head[7:0]);
                    second_d   = 1'b0;
                    cnt_d      = CntW'(T_SETUP - 1);
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(T_EHIGH - 1);
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(T_HOLD - 1);
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    if (BUS_WIDTH == 4 && !second_q) begin
                        second_d   = 1'b1;
                        lcd_data_d = BUS_WIDTH'(byte_q[3:0]);
                        cnt_d      = CntW'(T_SETUP - 1);
                        state_d    = StSetup;
                    end else begin
                        cnt_d   = slow ? CntW'(T_SLOW - 1) : CntW'(T_CMD - 1);
                        state_d = StWait;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWait: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            default: state_d = StIdle;
        endcase
        lcd_e_d = (state_d == StStrobe);
    end

    always_ff @(posedge refclk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            byte_q     <= '0;
            second_q   <= 1'b0;
            lcd_data_q <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_e_q    <= 1'b0;
            overflow_q <= 1'b0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            second_q   <= second_d;
            lcd_data_q <= lcd_data_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_e_q    <= lcd_e_d;
            overflow_q <= overflow_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset; push is held off while reset is high.
    always_ff @(posedge refclk_i) begin
        if (push) mem_q[wr_ptr_q] <= {wr_rs_i, wr_data_i};
    end

    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;
    assign busy_o       = (state_q != StIdle) || (level_q != '0);
    assign lcd_data_o   = lcd_data_q;
    assign lcd_rs_o     = lcd_rs_q;
    assign lcd_e_o      = lcd_e_q;

endmodule

// File: tb/tb_post_lcd_writer.sv
// Bench for post_lcd_writer: 4-bit and 8-bit instances share one stimulus stream
// and are checked every cycle against a timeline model plus directed literals.
module tb_post_lcd_writer;

    localparam int TS = 1, TE = 1, TH = 1, TC = 80, TW = 3280, DEPTH = 16;
    localparam int P = TS + TE + TH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic       wrs = 1'b0;
    logic       wvalid = 1'b0;

    logic       rdy4, ovf4, busy4, rs4, e4;
    logic [4:0] lvl4;
    logic [3:0] d4;
    logic       rdy8, ovf8, busy8, rs8, e8;
    logic [4:0] lvl8;
    logic [7:0] d8;

    post_lcd_writer #(.BUS_WIDTH(4)) dut4 (
        .refclk_i(clk), .reset_i(rst), .wr_data_i(wdata), .wr_rs_i(wrs),
        .wr_valid_i(wvalid), .wr_ready_o(rdy4), .fifo_level_o(lvl4), .overflow_o(ovf4),
        .busy_o(busy4), .lcd_data_o(d4), .lcd_rs_o(rs4), .lcd_e_o(e4)
    );

    post_lcd_writer #(.BUS_WIDTH(8)) dut8 (
        .refclk_i(clk), .reset_i(rst), .wr_data_i(wdata), .wr_rs_i(wrs),
        .wr_valid_i(wvalid), .wr_ready_o(rdy8), .fifo_level_o(lvl8), .overflow_o(ovf8),
        .busy_o(busy8), .lcd_data_o(d8), .lcd_rs_o(rs8), .lcd_e_o(e8)
    );

    initial forever #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each byte occupies a fixed timeline of nn*P bus cycles plus its wait.
    logic [8:0] mbuf [2][64];
    int         mhead [2];
    int         mcnt [2];
    bit         mact [2];
    int         mt [2];
    int         mlen [2];
    logic [8:0] ment [2];
    bit         me [2];
    logic [7:0] md [2];
    bit         mrs [2];
    bit         mov [2];

    always @(posedge clk) begin
        int  bw, nn, r, i;
        bit  room, psh;
        for (int k = 0; k < 2; k++) begin
            bw = (k == 0) ? 4 : 8;
            nn = 8 / bw;
            if (rst) begin
                mhead[k] = 0; mcnt[k] = 0; mact[k] = 0; mt[k] = 0;
                me[k] = 0; md[k] = 0; mrs[k] = 0; mov[k] = 0;
            end else begin
                room = (mcnt[k] < DEPTH);
                psh  = wvalid && room;
                if (wvalid && !room) mov[k] = 1;
                if (mact[k]) begin
                    if (mt[k] + 1 == mlen[k]) mact[k] = 0;
                    else mt[k]++;
                end else if (mcnt[k] > 0) begin
                    ment[k]  = mbuf[k][mhead[k]];
                    mhead[k] = (mhead[k] + 1) % 64;
                    mcnt[k]--;
                    mact[k]  = 1;
                    mt[k]    = 0;
                    mlen[k]  = nn * P + ((!ment[k][8] && ment[k][7:0] >= 1 && ment[k][7:0] <= 3)
                               ? TW : TC);
                end
                if (psh) begin
                    mbuf[k][(mhead[k] + mcnt[k]) % 64] = {wrs, wdata};
                    mcnt[k]++;
                end
                me[k] = 0;
                if (mact[k] && mt[k] < nn * P) begin
                    r = mt[k] % P;
                    i = mt[k] / P;
                    me[k]  = (r >= TS) && (r < TS + TE);
                    md[k]  = (bw == 8) ? ment[k][7:0] : ((i == 0) ? {4'h0, ment[k][7:4]}
                                                                  : {4'h0, ment[k][3:0]});
                    mrs[k] = ment[k][8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("e4", 32'(e4), 32'(me[0]));
            chk("data4", 32'(d4), 32'(md[0]));
            chk("rs4", 32'(rs4), 32'(mrs[0]));
            chk("level4", 32'(lvl4), 32'(mcnt[0]));
            chk("ready4", 32'(rdy4), 32'(!rst && mcnt[0] < DEPTH));
            chk("ovf4", 32'(ovf4), 32'(mov[0]));
            chk("busy4", 32'(busy4), 32'(mact[0] || mcnt[0] > 0));
            chk("e8", 32'(e8), 32'(me[1]));
            chk("data8", 32'(d8), 32'(md[1]));
            chk("rs8", 32'(rs8), 32'(mrs[1]));
            chk("level8", 32'(lvl8), 32'(mcnt[1]));
            chk("ready8", 32'(rdy8), 32'(!rst && mcnt[1] < DEPTH));
            chk("ovf8", 32'(ovf8), 32'(mov[1]));
            chk("busy8", 32'(busy8), 32'(mact[1] || mcnt[1] > 0));
        end
    end

    // Strobe capture: {rs, data} latched on every lcd_e rising edge.
    logic [8:0] cap4 [256];
    logic [8:0] cap8 [256];
    int         ecnt4 = 0, ecnt8 = 0;
    bit         pe4 = 0, pe8 = 0;

    always @(negedge clk) begin
        if (e4 && !pe4) begin cap4[8'(ecnt4)] = {rs4, 4'h0, d4}; ecnt4++; end
        if (e8 && !pe8) begin cap8[8'(ecnt8)] = {rs8, d8}; ecnt8++; end
        pe4 = e4;
        pe8 = e8;
    end

    function automatic logic [8:0] byte4(input int idx);
        logic [8:0] hi, lo;
        hi = cap4[8'(idx)];
        lo = cap4[8'(idx + 1)];
        return {hi[8], hi[3:0], lo[3:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        for (int c = 0; c < bound; c++) begin
            if (!busy4 && !busy8) break;
            tick();
        end
        chk(nm, 32'(busy4 || busy8), 32'd0);
    endtask

    logic [7:0] sent [20];
    int         base4, base8, cyc, rises, rise1, rise3, busy_fall;
    bit         prev;

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); chk_en = 1'b1;
        tick();
        chk("ready_in_reset", 32'(rdy4), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 32'(rdy4), 32'd1);
        chk("level_reset", 32'(lvl4), 32'd0);
        chk("busy_reset", 32'(busy4), 32'd0);
        chk("e_reset", 32'(e4), 32'd0);
        chk("data_reset", 32'({rs4, d4}), 32'd0);
        chk("ovf_reset", 32'(ovf4), 32'd0);

        // 1: 0x48 data byte on the 4-bit bus
        base4 = ecnt4;
        wvalid = 1'b1; wdata = 8'h48; wrs = 1'b1;
        tick(); wvalid = 1'b0;
        cyc = 0; rise1 = -1; busy_fall = -1;
        for (int c = 0; c < 200; c++) begin
            tick(); cyc++;
            if (e4 && rise1 < 0) rise1 = cyc;
            if (!busy4) begin busy_fall = cyc; break; end
        end
        chk("t1_first_e", 32'(rise1), 32'd2);
        chk("t1_busy_fall", 32'(busy_fall), 32'd87);
        wait_idle("t1_idle", 200);
        chk("t1_strobes", 32'(ecnt4 - base4), 32'd2);
        chk("t1_byte", 32'(byte4(base4)), 32'h148);

        // 2: clear command followed by a data byte
        base4 = ecnt4;
        wvalid = 1'b1; wdata = 8'h01; wrs = 1'b0;
        tick(); wdata = 8'h41; wrs = 1'b1;
        tick(); wvalid = 1'b0;
        cyc = 1; rises = 0; prev = 0; rise3 = -1; busy_fall = -1;
        for (int c = 0; c < 4000; c++) begin
            tick(); cyc++;
            if (e4 && !prev) begin rises++; if (rises == 3) rise3 = cyc; end
            prev = e4;
            if (!busy4) begin busy_fall = cyc; break; end
        end
        chk("t2_second_e", 32'(rise3), 32'd3289);
        chk("t2_busy_fall", 32'(busy_fall), 32'd3374);
        wait_idle("t2_idle", 4000);
        chk("t2_byte0", 32'(byte4(base4)), 32'h001);
        chk("t2_byte1", 32'(byte4(base4 + 2)), 32'h141);

        // 3: 20 back-to-back writes overrun the FIFO
        base4 = ecnt4;
        for (int i = 0; i < 20; i++) sent[i] = 8'($urandom);
        wvalid = 1'b1; wrs = 1'b1;
        for (int i = 0; i < 20; i++) begin wdata = sent[i]; tick(); end
        wvalid = 1'b0;
        chk("t3_level", 32'(lvl4), 32'd16);
        chk("t3_ready", 32'(rdy4), 32'd0);
        chk("t3_ovf", 32'(ovf4), 32'd1);
        wait_idle("t3_idle", 4000);
        chk("t3_strobes", 32'(ecnt4 - base4), 32'd34);
        for (int i = 0; i < 17; i++)
            chk("t3_order", 32'(byte4(base4 + 2 * i)), 32'({1'b1, sent[i]}));

        // 4: 8-bit instance, single strobe carrying the full byte
        base8 = ecnt8;
        wvalid = 1'b1; wdata = 8'hA5; wrs = 1'b1;
        tick(); wvalid = 1'b0;
        wait_idle("t4_idle", 300);
        chk("t4_strobes", 32'(ecnt8 - base8), 32'd1);
        chk("t4_byte", 32'(cap8[8'(base8)]), 32'h1A5);

        // 5: reset during a strobe discards everything
        wvalid = 1'b1; wrs = 1'b1;
        for (int i = 0; i < 3; i++) begin wdata = 8'h61 + 8'(i); tick(); end
        wvalid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (e4) break;
            tick();
        end
        chk("t5_in_strobe", 32'(e4), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_e_dropped", 32'(e4), 32'd0);
        chk("t5_level", 32'(lvl4), 32'd0);
        rst = 1'b0;
        base4 = ecnt4; base8 = ecnt8;
        repeat (300) tick();
        chk("t5_no_strobes", 32'((ecnt4 - base4) + (ecnt8 - base8)), 32'd0);

        // 6: stream 0x30..0x39
        base4 = ecnt4;
        wvalid = 1'b1; wrs = 1'b1;
        for (int i = 0; i < 10; i++) begin wdata = 8'h30 + 8'(i); tick(); end
        wvalid = 1'b0;
        wait_idle("t6_idle", 2000);
        chk("t6_strobes", 32'(ecnt4 - base4), 32'd20);
        for (int i = 0; i < 10; i++)
            chk("t6_byte", 32'(byte4(base4 + 2 * i)), 32'(9'h130 + 9'(i)));

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            wvalid = ($urandom_range(0, 3) == 0);
            wdata  = 8'($urandom);
            wrs    = 1'($urandom);
            if (!wrs && wdata >= 8'd1 && wdata <= 8'd3) wdata = wdata | 8'h10;
            tick();
        end
        wvalid = 1'b0;
        wait_idle("rand_idle", 20000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
